// File: rtl/rob_drain_scheduler_pkg.sv
// Shared widths, item field layout and FSM encoding for the ROB drain scheduler.
package rob_drain_scheduler_pkg;

  localparam int unsigned ROW_W      = 11;
  localparam int unsigned COL_W      = 8;
  localparam int unsigned ROB_ITEM_W = 24;

  localparam int unsigned ITEM_VLD_BIT  = 0;
  localparam int unsigned ITEM_COL_LSB  = 1;
  localparam int unsigned ITEM_COL_MSB  = 8;
  localparam int unsigned ITEM_LOS_BIT  = 9;
  localparam int unsigned ITEM_SIZE_LSB = 10;
  localparam int unsigned ITEM_SIZE_MSB = 11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    WAIT    = 3'd2,
    COLLECT = 3'd3,
    ISSUE   = 3'd4
  } state_e;

  typedef struct packed {
    logic [1:0]       size;
    logic             los;
    logic [COL_W-1:0] col;
  } cmd_t;

endpackage

// File: rtl/rob_drain_scheduler_sync_fifo.sv
// Single-clock FIFO with registered count/full; push on full and pop on empty are ignored.
module rob_drain_scheduler_sync_fifo #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [DW-1:0]          wdata,
  input  logic                   pop,
  output logic [DW-1:0]          rdata,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt_n;
  logic          do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && (count != '0);
  assign cnt_n   = count + CW'(do_push) - CW'(do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= cnt_n;
      full  <= (cnt_n == CW'(DEPTH));
    end
  end

  // Payload storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/rob_drain_scheduler.sv
// Drains pending DRAM rows: one ROB row-read per row, captures the item burst,
// then replays it as row-grouped column commands over valid/ready.
module rob_drain_scheduler
  import rob_drain_scheduler_pkg::*;
#(
  parameter int unsigned ROWQ_DEPTH  = 4,
  parameter int unsigned ITEMQ_DEPTH = 8,
  parameter int unsigned RD_TIMEOUT  = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  row_valid,
  input  logic [ROW_W-1:0]      row,
  output logic                  row_ready,
  output logic                  rob_rd,
  output logic [ROW_W-1:0]      rob_row,
  input  logic                  rob_item_valid,
  input  logic [ROB_ITEM_W-1:0] rob_item,
  input  logic                  rob_item_end,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [ROW_W-1:0]      cmd_row,
  output logic [COL_W-1:0]      cmd_col,
  output logic [1:0]            cmd_size,
  output logic                  cmd_los,
  output logic                  cmd_first,
  output logic                  cmd_last,
  output logic                  busy,
  output logic                  timeout_err,
  output logic                  overflow_err
);

  localparam int unsigned RCW = $clog2(ROWQ_DEPTH) + 1;
  localparam int unsigned ICW = $clog2(ITEMQ_DEPTH) + 1;
  localparam int unsigned TW  = $clog2(RD_TIMEOUT + 1);

  state_e           state, state_n;
  logic [ROW_W-1:0] row_head, cur_row;
  logic             row_full, row_pop;
  logic [RCW-1:0]   row_count;
  cmd_t             item_in, item_head;
  logic             item_full, item_cap, item_wr, item_drop, item_pop;
  logic [ICW-1:0]   item_count;
  logic [TW-1:0]    tmr, tmr_n;
  logic             tmo, first_pend, cmd_free, buf_empty_at_end;
  logic             unused_item_hi;

  rob_drain_scheduler_sync_fifo #(.DW(ROW_W), .DEPTH(ROWQ_DEPTH)) u_row_q (
    .clk   (clk),
    .reset (reset),
    .push  (row_valid),
    .wdata (row),
    .pop   (row_pop),
    .rdata (row_head),
    .full  (row_full),
    .count (row_count)
  );

  rob_drain_scheduler_sync_fifo #(.DW($bits(cmd_t)), .DEPTH(ITEMQ_DEPTH)) u_item_q (
    .clk   (clk),
    .reset (reset),
    .push  (item_wr),
    .wdata (item_in),
    .pop   (item_pop),
    .rdata (item_head),
    .full  (item_full),
    .count (item_count)
  );

  // Only the command fields are buffered; bits above the size field are not used here.
  assign item_in = '{size: rob_item[ITEM_SIZE_MSB:ITEM_SIZE_LSB],
                     los:  rob_item[ITEM_LOS_BIT],
                     col:  rob_item[ITEM_COL_MSB:ITEM_COL_LSB]};
  assign unused_item_hi = ^rob_item[ROB_ITEM_W-1:ITEM_SIZE_MSB+1];

  assign item_cap  = ((state == WAIT) || (state == COLLECT)) && rob_item_valid
                     && rob_item[ITEM_VLD_BIT];
  assign item_wr   = item_cap && !item_full;
  assign item_drop = item_cap && item_full;
  assign buf_empty_at_end = (item_count == '0) && !item_wr;
  assign cmd_free  = !cmd_valid || cmd_ready;
  assign row_ready = !row_full;
  assign rob_row   = cur_row;

  always_comb begin
    state_n  = state;
    tmr_n    = tmr;
    row_pop  = 1'b0;
    item_pop = 1'b0;
    tmo      = 1'b0;
    case (state)
      IDLE: begin
        if (row_count != '0) begin
          row_pop = 1'b1;
          state_n = REQ;
        end
      end
      REQ: begin
        tmr_n   = '0;
        state_n = WAIT;
      end
      WAIT: begin
        if (rob_item_valid) begin
          if (rob_item_end) state_n = buf_empty_at_end ? IDLE : ISSUE;
          else              state_n = COLLECT;
        end else if (tmr == TW'(RD_TIMEOUT - 2)) begin
          // Decided one cycle early so the registered pulse lands RD_TIMEOUT cycles after rob_rd.
          tmo     = 1'b1;
          state_n = IDLE;
        end else begin
          tmr_n = tmr + TW'(1);
        end
      end
      COLLECT: begin
        if (rob_item_end) state_n = buf_empty_at_end ? IDLE : ISSUE;
      end
      ISSUE: begin
        if (cmd_free) begin
          if (item_count != '0) item_pop = 1'b1;
          else                  state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      tmr          <= '0;
      cur_row      <= '0;
      first_pend   <= 1'b0;
      rob_rd       <= 1'b0;
      busy         <= 1'b0;
      timeout_err  <= 1'b0;
      overflow_err <= 1'b0;
      cmd_valid    <= 1'b0;
      cmd_row      <= '0;
      cmd_col      <= '0;
      cmd_size     <= '0;
      cmd_los      <= 1'b0;
      cmd_first    <= 1'b0;
      cmd_last     <= 1'b0;
    end else begin
      state        <= state_n;
      tmr          <= tmr_n;
      rob_rd       <= (state_n == REQ);
      busy         <= (state_n != IDLE);
      timeout_err  <= tmo;
      overflow_err <= item_drop;
      if (row_pop) cur_row <= row_head;
      if ((state_n == ISSUE) && (state != ISSUE)) first_pend <= 1'b1;
      // Output stage: refill from the buffer head whenever it is empty or being accepted.
      if (item_pop) begin
        cmd_valid  <= 1'b1;
        cmd_row    <= cur_row;
        cmd_col    <= item_head.col;
        cmd_size   <= item_head.size;
        cmd_los    <= item_head.los;
        cmd_first  <= first_pend;
        cmd_last   <= (item_count == ICW'(1));
        first_pend <= 1'b0;
      end else if (cmd_ready) begin
        cmd_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rob_drain_scheduler.sv
// Directed self-checking bench for rob_drain_scheduler.
module tb_rob_drain_scheduler;

  logic        clk = 1'b0;
  logic        reset, row_valid, row_ready, rob_rd;
  logic [10:0] row, rob_row, cmd_row;
  logic        rob_item_valid, rob_item_end;
  logic [23:0] rob_item;
  logic        cmd_valid, cmd_ready, cmd_los, cmd_first, cmd_last;
  logic [7:0]  cmd_col;
  logic [1:0]  cmd_size;
  logic        busy, timeout_err, overflow_err;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  rob_drain_scheduler dut (
    .clk(clk), .reset(reset), .row_valid(row_valid), .row(row), .row_ready(row_ready),
    .rob_rd(rob_rd), .rob_row(rob_row), .rob_item_valid(rob_item_valid),
    .rob_item(rob_item), .rob_item_end(rob_item_end), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_size(cmd_size),
    .cmd_los(cmd_los), .cmd_first(cmd_first), .cmd_last(cmd_last), .busy(busy),
    .timeout_err(timeout_err), .overflow_err(overflow_err)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] mk(input logic [7:0] col, input logic [1:0] size,
                                     input logic los, input logic vld);
    return {12'h5A5, size, los, col, vld};
  endfunction

  task automatic push_row(input logic [10:0] r);
    row_valid = 1'b1;
    row       = r;
    step();
    row_valid = 1'b0;
  endtask

  task automatic drive_item(input logic [23:0] it, input logic e);
    rob_item_valid = 1'b1;
    rob_item       = it;
    rob_item_end   = e;
    step();
    rob_item_valid = 1'b0;
    rob_item_end   = 1'b0;
  endtask

  task automatic wait_rd(input string tag, input logic [10:0] exp_row);
    int n = 0;
    while (!rob_rd && n < 40) begin
      step();
      n++;
    end
    chk({tag, "_rd"}, 32'(rob_rd), 32'd1);
    chk({tag, "_row"}, 32'(rob_row), 32'(exp_row));
  endtask

  task automatic expect_cmd(input string tag, input logic [10:0] r, input logic [7:0] col,
                            input logic [1:0] size, input logic los, input logic first,
                            input logic last);
    int n = 0;
    while (!cmd_valid && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_valid"}, 32'(cmd_valid), 32'd1);
    chk({tag, "_row"},   32'(cmd_row),   32'(r));
    chk({tag, "_col"},   32'(cmd_col),   32'(col));
    chk({tag, "_size"},  32'(cmd_size),  32'(size));
    chk({tag, "_los"},   32'(cmd_los),   32'(los));
    chk({tag, "_first"}, 32'(cmd_first), 32'(first));
    chk({tag, "_last"},  32'(cmd_last),  32'(last));
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed running, expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int seen;
    reset = 1'b1; row_valid = 1'b0; row = '0; rob_item_valid = 1'b0;
    rob_item = '0; rob_item_end = 1'b0; cmd_ready = 1'b1;
    @(negedge clk);
    step();
    step();
    reset = 1'b0;
    chk("rst_row_ready", 32'(row_ready), 32'd1);
    chk("rst_rob_rd", 32'(rob_rd), 32'd0);
    chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_errs", 32'({timeout_err, overflow_err}), 32'd0);
    step();

    // 1: basic three-item burst with ready held high
    push_row(11'h123);
    chk("t1_rd_lat0", 32'(rob_rd), 32'd0);
    step();
    chk("t1_rd", 32'(rob_rd), 32'd1);
    chk("t1_row", 32'(rob_row), 32'h123);
    chk("t1_busy", 32'(busy), 32'd1);
    step();
    chk("t1_rd_pulse", 32'(rob_rd), 32'd0);
    drive_item(mk(8'h10, 2'd1, 1'b0, 1'b1), 1'b0);
    drive_item(mk(8'h24, 2'd2, 1'b1, 1'b1), 1'b0);
    drive_item(mk(8'h3F, 2'd3, 1'b0, 1'b1), 1'b1);
    expect_cmd("t1_c0", 11'h123, 8'h10, 2'd1, 1'b0, 1'b1, 1'b0);
    expect_cmd("t1_c1", 11'h123, 8'h24, 2'd2, 1'b1, 1'b0, 1'b0);
    expect_cmd("t1_c2", 11'h123, 8'h3F, 2'd3, 1'b0, 1'b0, 1'b1);
    chk("t1_done_valid", 32'(cmd_valid), 32'd0);
    chk("t1_done_busy", 32'(busy), 32'd0);

    // 2: backpressure on the second command
    push_row(11'h0AB);
    wait_rd("t2", 11'h0AB);
    step();
    drive_item(mk(8'h10, 2'd1, 1'b0, 1'b1), 1'b0);
    drive_item(mk(8'h24, 2'd2, 1'b1, 1'b1), 1'b0);
    drive_item(mk(8'h3F, 2'd3, 1'b0, 1'b1), 1'b1);
    expect_cmd("t2_c0", 11'h0AB, 8'h10, 2'd1, 1'b0, 1'b1, 1'b0);
    cmd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_valid", 32'(cmd_valid), 32'd1);
      chk("t2_hold_fields", 32'({cmd_col, cmd_size, cmd_los, cmd_first, cmd_last}),
          32'({8'h24, 2'd2, 1'b1, 1'b0, 1'b0}));
      step();
    end
    cmd_ready = 1'b1;
    expect_cmd("t2_c1", 11'h0AB, 8'h24, 2'd2, 1'b1, 1'b0, 1'b0);
    expect_cmd("t2_c2", 11'h0AB, 8'h3F, 2'd3, 1'b0, 1'b0, 1'b1);
    chk("t2_no_dup", 32'(cmd_valid), 32'd0);

    // 3: fill the row queue while the FSM waits on an earlier row
    push_row(11'h200);
    wait_rd("t3_head", 11'h200);
    for (int i = 0; i < 5; i++) begin
      push_row(11'h301 + 11'(i));
      chk("t3_ready", 32'(row_ready), (i < 3) ? 32'd1 : 32'd0);
    end
    drive_item(mk(8'h01, 2'd0, 1'b0, 1'b1), 1'b1);
    expect_cmd("t3_c", 11'h200, 8'h01, 2'd0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      wait_rd("t3_drain", 11'h301 + 11'(i));
      if (i == 0) chk("t3_ready_back", 32'(row_ready), 32'd1);
      step();
      drive_item(mk(8'h00, 2'd0, 1'b0, 1'b0), 1'b1);
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (rob_rd) seen++;
      step();
    end
    chk("t3_fifth_ignored", 32'(seen), 32'd0);
    chk("t3_idle", 32'(busy), 32'd0);

    // 4: read timeout, then the next queued row is requested
    push_row(11'h0A1);
    push_row(11'h0A2);
    wait_rd("t4_a", 11'h0A1);
    k = 0;
    while (!timeout_err && k < 20) begin
      step();
      k++;
    end
    chk("t4_tmo_cycle", 32'(k), 32'd15);
    chk("t4_tmo_idle", 32'(busy), 32'd0);
    step();
    chk("t4_tmo_pulse", 32'(timeout_err), 32'd0);
    chk("t4_next_rd", 32'(rob_rd), 32'd1);
    chk("t4_next_row", 32'(rob_row), 32'h0A2);
    step();
    drive_item(mk(8'h00, 2'd0, 1'b0, 1'b0), 1'b1);
    chk("t4_b_idle", 32'(busy), 32'd0);

    // 5: nine valid items into an eight-deep buffer
    push_row(11'h055);
    wait_rd("t5", 11'h055);
    step();
    for (int i = 0; i < 9; i++) begin
      drive_item(mk(8'h40 + 8'(i), 2'(i), 1'(i), 1'b1), (i == 8));
      if (i == 7) chk("t5_no_ovf_yet", 32'(overflow_err), 32'd0);
    end
    chk("t5_ovf", 32'(overflow_err), 32'd1);
    step();
    chk("t5_ovf_pulse", 32'(overflow_err), 32'd0);
    for (int i = 0; i < 8; i++)
      expect_cmd("t5_c", 11'h055, 8'h40 + 8'(i), 2'(i), 1'(i), (i == 0), (i == 7));
    chk("t5_eight_only", 32'(cmd_valid), 32'd0);

    // 6: all-invalid burst produces nothing
    push_row(11'h066);
    wait_rd("t6", 11'h066);
    step();
    drive_item(mk(8'h11, 2'd1, 1'b0, 1'b0), 1'b0);
    drive_item(mk(8'h12, 2'd1, 1'b1, 1'b0), 1'b1);
    chk("t6_idle", 32'(busy), 32'd0);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (cmd_valid) seen++;
      step();
    end
    chk("t6_no_cmd", 32'(seen), 32'd0);

    // 6b: reset while issuing with items buffered
    push_row(11'h077);
    wait_rd("t6r", 11'h077);
    step();
    cmd_ready = 1'b0;
    drive_item(mk(8'h21, 2'd1, 1'b0, 1'b1), 1'b0);
    drive_item(mk(8'h22, 2'd2, 1'b1, 1'b1), 1'b0);
    drive_item(mk(8'h23, 2'd3, 1'b0, 1'b1), 1'b1);
    k = 0;
    while (!cmd_valid && k < 10) begin
      step();
      k++;
    end
    chk("t6r_issuing", 32'(cmd_valid), 32'd1);
    reset = 1'b1;
    step();
    chk("t6r_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("t6r_fields", 32'({cmd_row, cmd_col, cmd_size, cmd_los, cmd_first, cmd_last}), 32'd0);
    chk("t6r_busy", 32'(busy), 32'd0);
    chk("t6r_rd", 32'({rob_rd, rob_row}), 32'd0);
    chk("t6r_errs", 32'({timeout_err, overflow_err}), 32'd0);
    chk("t6r_row_ready", 32'(row_ready), 32'd1);
    reset = 1'b0;
    cmd_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (cmd_valid || rob_rd || timeout_err || overflow_err) seen++;
    end
    chk("t6r_quiet", 32'(seen), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
